// File: rtl/alu_pkg.sv
// Shared constants for the ALU slice: default operand width and op encoding.
package alu_pkg;

    localparam int   ALU_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor. Subtract is a + ~b + 1, so the carry-out reads
// as "no borrow" (a >= b unsigned) when sub is high.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // One adder serves both ops: invert b and inject the +1 as carry-in for subtract.
    always_comb begin
        b_eff  = (sub == OP_SUB) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
    end

endmodule

// File: rtl/alu.sv
// ALU driving a shared tri-state W bus, with optional registered carry/zero flags.
// Build option: define ALU_FLAGS_EN to include the flag registers; otherwise
// carry_flag and zero_flag are tied low and only the bus path remains.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output tri   [WIDTH-1:0] w_bus,
    output logic             carry_flag,
    output logic             zero_flag
);

    logic [WIDTH-1:0] result;
    logic             carry;
    logic             drive;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a      (a),
        .b      (b),
        .sub    (sub),
        .result (result),
        .carry  (carry)
    );

    // Bus is released whenever reset is held, so a resetting ALU never fights other drivers.
    assign drive = enable & rst_n;
    assign w_bus = drive ? result : {WIDTH{1'bz}};

`ifdef ALU_FLAGS_EN
    logic carry_p1;
    logic zero_p1;

    // Flag capture: load on enabled edges, hold otherwise, clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_p1 <= 1'b0;
            zero_p1  <= 1'b0;
        end else if (enable) begin
            carry_p1 <= carry;
            zero_p1  <= (result == '0);
        end
    end

    assign carry_flag = carry_p1;
    assign zero_flag  = zero_p1;
`else
    // Without flag registers the clock and adder carry have no consumer.
    logic unused_flag_inputs;
    assign unused_flag_inputs = clk ^ carry;

    assign carry_flag = 1'b0;
    assign zero_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: combinational bus result, tri-state release,
// flag capture/hold and asynchronous reset. Flag expectations follow ALU_FLAGS_EN.
module tb_alu;

    localparam int W = 8;

`ifdef ALU_FLAGS_EN
    localparam logic FLAGS_ON = 1'b1;
`else
    localparam logic FLAGS_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    tri   [W-1:0] w_bus;
    logic         carry_flag;
    logic         zero_flag;

    logic         probe_en;
    logic [W-1:0] probe_val;

    int pass_cnt;
    int chk_cnt;

    // A weak test driver on the bus: if the ALU has released it, the probe value reads back intact.
    assign w_bus = probe_en ? probe_val : {W{1'bz}};

    alu #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sub        (sub),
        .a          (a),
        .b          (b),
        .w_bus      (w_bus),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_flags(input string tag, input logic exp_c, input logic exp_z);
        check({tag, "_carry"}, {7'd0, carry_flag}, {7'd0, exp_c & FLAGS_ON});
        check({tag, "_zero"},  {7'd0, zero_flag},  {7'd0, exp_z & FLAGS_ON});
    endtask

    // Bus released: two distinct probe patterns must both read back unaltered.
    task automatic check_z(input string tag);
        probe_en  = 1'b1;
        probe_val = 8'hA5;
        #1;
        check({tag, "_zA5"}, w_bus, 8'hA5);
        probe_val = 8'h5A;
        #1;
        check({tag, "_z5A"}, w_bus, 8'h5A);
        probe_en  = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        chk_cnt   = 0;
        probe_en  = 1'b0;
        probe_val = '0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        sub       = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        // Reset with the bus idle
        tick();
        check_flags("rst", 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check_z("idle");
        check_flags("idle", 1'b0, 1'b0);

        // 3 + 1, then 3 - 1, then release
        a = 8'h03; b = 8'h01; sub = 1'b0; enable = 1'b1;
        #1;
        check("add_3_1", w_bus, 8'h04);
        tick();
        check_flags("add_3_1", 1'b0, 1'b0);
        sub = 1'b1;
        #1;
        check("sub_3_1", w_bus, 8'h02);
        tick();
        check_flags("sub_3_1", 1'b1, 1'b0);
        enable = 1'b0;
        #1;
        check_z("drop_en");

        // FF + 01 wraps to 00 with carry
        a = 8'hFF; b = 8'h01; sub = 1'b0; enable = 1'b1;
        #1;
        check("add_wrap", w_bus, 8'h00);
        tick();
        check_flags("add_wrap", 1'b1, 1'b1);

        // 00 - 01 borrows to FF
        a = 8'h00; b = 8'h01; sub = 1'b1;
        #1;
        check("sub_wrap", w_bus, 8'hFF);
        tick();
        check_flags("sub_wrap", 1'b0, 1'b0);

        // Hold cleared flags while inputs would set both
        enable = 1'b0; a = 8'hFF; b = 8'h01; sub = 1'b0;
        tick(); tick(); tick();
        check_flags("hold0", 1'b0, 1'b0);

        // Equal operands subtract to zero without borrow
        enable = 1'b1; a = 8'h55; b = 8'h55; sub = 1'b1;
        #1;
        check("sub_eq", w_bus, 8'h00);
        tick();
        check_flags("sub_eq", 1'b1, 1'b1);

        // Hold set flags while inputs would clear both
        enable = 1'b0; a = 8'h10; b = 8'h20; sub = 1'b1;
        tick(); tick(); tick();
        check_flags("hold1", 1'b1, 1'b1);

        // 10 - 20 borrows, nonzero result
        enable = 1'b1;
        #1;
        check("sub_borrow", w_bus, 8'hF0);
        tick();
        check_flags("sub_borrow", 1'b0, 1'b0);

        // 80 + 80 overflows to zero, setting both flags for the reset test
        a = 8'h80; b = 8'h80; sub = 1'b0;
        #1;
        check("add_ovf", w_bus, 8'h00);
        tick();
        check_flags("add_ovf", 1'b1, 1'b1);

        // Reset between edges with enable high: flags clear at once, bus released
        a = 8'h03; b = 8'h01; sub = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 1'b0, 1'b0);
        check_z("rst_bus");

        // An edge inside reset captures nothing
        a = 8'hFF; b = 8'h01;
        tick();
        check_flags("rst_edge", 1'b0, 1'b0);

        // Release between edges; first capture waits for the next edge
        #2;
        rst_n = 1'b1;
        #1;
        check_flags("release", 1'b0, 1'b0);
        check("release_bus", w_bus, 8'h00);
        tick();
        check_flags("first_cap", 1'b1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, meaning operand and result bit width.
REQ-002 The block SHALL have port clk  input  1  system clock; all flag registers update on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port enable  input  1  drive result onto w_bus and capture flags when high.
REQ-005 The block SHALL have port sub  input  1  operation select: 0 = add, 1 = subtract.
REQ-006 The block SHALL have port a  input  WIDTH  accumulator operand.
REQ-007 The block SHALL have port b  input  WIDTH  B-register operand.
REQ-008 The block SHALL have port w_bus  output (tri-state)  WIDTH  shared W bus.
REQ-009 The block SHALL have port carry_flag  output  1  registered carry-out of the last enabled operation.
REQ-010 The block SHALL have port zero_flag  output  1  registered result-equals-zero of the last enabled operation.

Function
REQ-011 The result SHALL be combinational: add = (a + b) mod 2^WIDTH; subtract = (a + ~b + 1) mod 2^WIDTH, two's complement.
REQ-012 Carry SHALL be the adder carry-out of bit WIDTH-1: add → overflow; subtract → 1 means no borrow (a >= b unsigned).
REQ-013 With enable=1 and rst_n=1, w_bus SHALL carry the result in the same cycle; zero latency, no clock involved.
REQ-014 With enable=0, w_bus SHALL be high-impedance (all bits Z).
REQ-015 A change of sub, a or b while enable=1 SHALL be reflected on w_bus combinationally without glitch-free guarantees.
REQ-016 On each rising clk edge with enable=1, carry_flag and zero_flag SHALL load the current carry and (result == 0).
REQ-017 With enable=0, flags SHALL hold their value.
REQ-018 Wrap-around SHALL be silent: 0xFF + 0x01 = 0x00 with carry 1; 0x00 - 0x01 = 0xFF with carry 0.

Reset
REQ-019 While rst_n=0, carry_flag and zero_flag SHALL be 0 immediately, independent of clk.
REQ-020 While rst_n=0, w_bus SHALL be high-impedance regardless of enable.
REQ-021 Reset asserted mid-operation SHALL abort flag capture; the first capture after release occurs on the first rising edge with rst_n=1 and enable=1.

Configuration
REQ-022 With macro ALU_FLAGS_EN defined, the flag registers and the carry_flag and zero_flag ports SHALL be present as specified.
REQ-023 Without ALU_FLAGS_EN, the flag registers SHALL be omitted and carry_flag and zero_flag SHALL be tied to 0; w_bus behaviour SHALL be unchanged.

Structure
REQ-024 Shared package alu_pkg SHALL hold the default WIDTH constant and the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-025 One sub-module alu_addsub SHALL implement the WIDTH-bit adder/subtractor (inputs a, b, sub; outputs result, carry), instantiated once.

Verification
REQ-026 Reset then enable=0 with a=0x00 and b=0x00 → w_bus = Z; flags = 0.
REQ-027 a=0x03, b=0x01, sub=0, enable=1 → w_bus=0x04; after clk, carry=0 and zero=0; then sub=1 → w_bus=0x02; drop enable → w_bus = Z.
REQ-028 a=0xFF, b=0x01, add, enable=1, clk → w_bus=0x00, carry=1, zero=1.
REQ-029 a=0x00, b=0x01, sub, enable=1, clk → w_bus=0xFF, carry=0, zero=0; then enable=0 for 3 clks → flags held.
REQ-030 With flags set, assert rst_n=0 between clock edges → flags clear at once and w_bus = Z while enable=1.
REQ-031 Build without ALU_FLAGS_EN, repeat REQ-028 → w_bus=0x00 and both flags remain 0.
